// File: rtl/instr_reg_pkg.sv
// Shared CPU definitions: opcode map, fetch-phase encodings and the
// instruction-register FSM state encodings used by the IR and the controller.
package instr_reg_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDO = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STO = 3'b011;
    localparam logic [2:0] OP_PRE = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_LDM = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] FETCH_IDLE = 2'b00;
    localparam logic [1:0] FETCH_HI   = 2'b01;
    localparam logic [1:0] FETCH_LO   = 2'b10;
    localparam logic [1:0] FETCH_ILL  = 2'b11;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_HI    = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    // Single-byte instructions need no low-byte fetch.
    function automatic logic is_single_byte(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_PRE) || (op == OP_ADD) ||
               (op == OP_LDM) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/instr_reg.sv
// Instruction register: captures the high byte (opcode + short address) and
// the optional low byte from ROM under the controller's fetch phase.
module instr_reg
    import instr_reg_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [1:0]             fetch,
    input  logic [DATA_W-1:0]      data,
    output logic [OP_W-1:0]        ins,
    output logic [DATA_W-OP_W-1:0] ad1,
    output logic [DATA_W-1:0]      ad2,
    output logic                   ir_full,
    output logic                   seq_err,
    output logic [7:0]             instr_cnt,
    output logic [1:0]             state_o
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] ad2_q, ad2_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    // Handshake: a load is accepted on a rising clk when ena=1 and fetch is
    // 01, or 10 while in HI. Anything else with ena=1 and fetch!=00 is a
    // sequence error; with ena=0 the inputs are not looked at.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        ad2_d   = ad2_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (ena) begin
            case (fetch)
                FETCH_HI: begin
                    hi_d    = data;
                    ad2_d   = '0;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = ST_HI;
                end
                FETCH_LO: begin
                    if (state_q == ST_HI) begin
                        ad2_d   = data;
                        state_d = ST_FULL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                FETCH_ILL: begin
                    err_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            hi_q    <= '0;
            ad2_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            ad2_q   <= ad2_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign ins       = hi_q[DATA_W-1 -: OP_W];
    assign ad1       = hi_q[DATA_W-OP_W-1:0];
    assign ad2       = ad2_q;
    assign ir_full   = (state_q == ST_FULL);
    assign seq_err   = err_q;
    assign instr_cnt = cnt_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_instr_reg.sv
// Directed bench for instr_reg: a cumulative vector table from reset plus
// hand-written sequences for error stickiness, async reset and counter wrap.
module tb_instr_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [1:0] fetch;
    logic [7:0] data;
    logic [2:0] ins;
    logic [4:0] ad1;
    logic [7:0] ad2;
    logic       ir_full;
    logic       seq_err;
    logic [7:0] instr_cnt;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] S_E = 2'b00;
    localparam logic [1:0] S_H = 2'b01;
    localparam logic [1:0] S_F = 2'b10;

    instr_reg #(.DATA_W(8), .OP_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .fetch     (fetch),
        .data      (data),
        .ins       (ins),
        .ad1       (ad1),
        .ad2       (ad2),
        .ir_full   (ir_full),
        .seq_err   (seq_err),
        .instr_cnt (instr_cnt),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ena;
        logic [1:0] fetch;
        logic [7:0] data;
        logic [2:0] e_ins;
        logic [4:0] e_ad1;
        logic [7:0] e_ad2;
        logic       e_full;
        logic       e_err;
        logic [7:0] e_cnt;
        logic [1:0] e_state;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] e_ins, input logic [4:0] e_ad1,
                           input logic [7:0] e_ad2, input logic e_full, input logic e_err,
                           input logic [7:0] e_cnt, input logic [1:0] e_state);
        chk({tag, ".ins"},   {29'd0, ins},       {29'd0, e_ins});
        chk({tag, ".ad1"},   {27'd0, ad1},       {27'd0, e_ad1});
        chk({tag, ".ad2"},   {24'd0, ad2},       {24'd0, e_ad2});
        chk({tag, ".full"},  {31'd0, ir_full},   {31'd0, e_full});
        chk({tag, ".err"},   {31'd0, seq_err},   {31'd0, e_err});
        chk({tag, ".cnt"},   {24'd0, instr_cnt}, {24'd0, e_cnt});
        chk({tag, ".state"}, {30'd0, state_o},   {30'd0, e_state});
    endtask

    task automatic step(input logic e, input logic [1:0] f, input logic [7:0] d);
        @(negedge clk);
        ena   = e;
        fetch = f;
        data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ena   = 1'b0;
        fetch = 2'b00;
        data  = 8'h00;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        ena   = 1'b0;
        fetch = 2'b00;
        data  = 8'h00;
        #1;
        chk_all("reset", 3'd0, 5'd0, 8'h00, 1'b0, 1'b0, 8'd0, S_E);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //           ena  fetch  data   ins   ad1     ad2    full  err   cnt   state
        vecs[0]  = '{1'b1, 2'b01, 8'h00, 3'd0, 5'h00, 8'h00, 1'b0, 1'b0, 8'd1, S_H};
        vecs[1]  = '{1'b1, 2'b01, 8'h4A, 3'd2, 5'h0A, 8'h00, 1'b0, 1'b0, 8'd2, S_H};
        vecs[2]  = '{1'b1, 2'b10, 8'h3C, 3'd2, 5'h0A, 8'h3C, 1'b1, 1'b0, 8'd2, S_F};
        vecs[3]  = '{1'b1, 2'b01, 8'hA0, 3'd5, 5'h00, 8'h00, 1'b0, 1'b0, 8'd3, S_H};
        vecs[4]  = '{1'b1, 2'b01, 8'hE0, 3'd7, 5'h00, 8'h00, 1'b0, 1'b0, 8'd4, S_H};
        vecs[5]  = '{1'b0, 2'b01, 8'h55, 3'd7, 5'h00, 8'h00, 1'b0, 1'b0, 8'd4, S_H};
        vecs[6]  = '{1'b0, 2'b11, 8'hAA, 3'd7, 5'h00, 8'h00, 1'b0, 1'b0, 8'd4, S_H};
        vecs[7]  = '{1'b0, 2'b10, 8'h99, 3'd7, 5'h00, 8'h00, 1'b0, 1'b0, 8'd4, S_H};
        vecs[8]  = '{1'b1, 2'b00, 8'h77, 3'd7, 5'h00, 8'h00, 1'b0, 1'b0, 8'd4, S_H};
        vecs[9]  = '{1'b1, 2'b10, 8'h12, 3'd7, 5'h00, 8'h12, 1'b1, 1'b0, 8'd4, S_F};
        vecs[10] = '{1'b1, 2'b10, 8'hFF, 3'd7, 5'h00, 8'h12, 1'b1, 1'b1, 8'd4, S_F};
        vecs[11] = '{1'b1, 2'b01, 8'h3F, 3'd1, 5'h1F, 8'h00, 1'b0, 1'b1, 8'd5, S_H};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].ena, vecs[i].fetch, vecs[i].data);
            chk_all($sformatf("vec%0d", i), vecs[i].e_ins, vecs[i].e_ad1, vecs[i].e_ad2,
                    vecs[i].e_full, vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_state);
        end

        // Low byte from EMPTY: rejected, error sticks through later legal loads.
        do_reset();
        step(1'b1, 2'b10, 8'hFF);
        chk_all("lo_from_empty", 3'd0, 5'd0, 8'h00, 1'b0, 1'b1, 8'd0, S_E);
        step(1'b1, 2'b01, 8'h4A);
        chk_all("err_sticky_hi", 3'd2, 5'h0A, 8'h00, 1'b0, 1'b1, 8'd1, S_H);
        step(1'b1, 2'b10, 8'h3C);
        chk_all("err_sticky_lo", 3'd2, 5'h0A, 8'h3C, 1'b1, 1'b1, 8'd1, S_F);

        // Illegal fetch encoding in HI: no load, state held, error set.
        do_reset();
        step(1'b1, 2'b01, 8'h6F);
        step(1'b1, 2'b11, 8'hC3);
        chk_all("fetch11", 3'd3, 5'h0F, 8'h00, 1'b0, 1'b1, 8'd1, S_H);

        // Async reset mid-instruction, then the first edge after release loads.
        do_reset();
        step(1'b1, 2'b01, 8'h6F);
        chk_all("pre_rst_hi", 3'd3, 5'h0F, 8'h00, 1'b0, 1'b0, 8'd1, S_H);
        @(negedge clk);
        ena   = 1'b0;
        fetch = 2'b00;
        rst   = 1'b1;
        #1;
        chk_all("async_rst", 3'd0, 5'd0, 8'h00, 1'b0, 1'b0, 8'd0, S_E);
        @(negedge clk);
        rst   = 1'b0;
        ena   = 1'b1;
        fetch = 2'b01;
        data  = 8'h21;
        @(posedge clk);
        #1;
        chk_all("post_rst_load", 3'd1, 5'h01, 8'h00, 1'b0, 1'b0, 8'd1, S_H);

        // Counter wrap after 256 high-byte loads.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 2'b01, 8'(i));
        end
        chk("cnt_255", {24'd0, instr_cnt}, 32'd255);
        step(1'b1, 2'b01, 8'hFF);
        chk_all("cnt_wrap", 3'd7, 5'h1F, 8'h00, 1'b0, 1'b0, 8'd0, S_H);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
